alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
Bit-serial sequencer that drives the existing combinational 1-bit ALU slice (a, b, sm, sa, sb, c_in, op -> result, c_out) as its initiator. It turns that slice into a WIDTH-bit arithmetic unit by presenting operand bits LSB-first, one per clock, and feeding c_out back into c_in. It collects the result bits, then reports result, carry and zero with a start/busy/done handshake. It sits between the pipeline's execute-stage control and the slice instance.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).
CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  request; sampled only in IDLE
a_in  in  WIDTH  operand A, captured on accepted start
b_in  in  WIDTH  operand B, captured on accepted start
op_in  in  2  slice op, captured on accepted start
sm_in, sa_in, sb_in  in  1 each  slice mode/select controls, captured on accepted start
cin_in  in  1  initial carry-in for bit 0, captured on accepted start
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; result_out, carry_out and zero valid this cycle
result_out  out  WIDTH  assembled result; held until next accepted start
carry_out  out  1  final slice c_out of bit WIDTH-1
zero  out  1  result_out == 0
slc_a, slc_b, slc_cin  out  1 each  to slice a/b/c_in
slc_op  out  2  to slice op
slc_sm, slc_sa, slc_sb  out  1 each  to slice sm/sa/sb
slc_result, slc_cout  in  1 each  from slice result/c_out

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, counter=0, all outputs 0, all slc_* outputs 0, carry register 0, internal shift registers 0. Reset wins over every other event. Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: on start=1, latch a_in, b_in, op_in, sm/sa/sb, cin_in; counter=0; go to RUN. Call this edge E0.
- RUN, cycle i+1 after E0 (i = 0..WIDTH-1):
  - Drive slc_a = A[i], slc_b = B[i], slc_cin = carry register (cin_in for i=0).
  - Drive slc_op/sm/sa/sb from the latched values.
  - At the closing edge: shift slc_result into the result register MSB-side with a right shift, so bit i lands at position i after WIDTH shifts.
  - At the same edge: carry register <= slc_cout, counter++.
  - After the edge with counter == WIDTH-1, go to DONE.
- DONE (cycle WIDTH+1 after E0):
  - done=1; result_out and carry_out (= last slc_cout) valid; zero valid.
  - slc_* outputs driven to 0.
  - Next edge returns to IDLE.
- Latency: done asserted exactly WIDTH+1 cycles after the start edge. Throughput: one operation per WIDTH+2 cycles.
- start is ignored in RUN and DONE, with no queuing. Operand inputs may change freely after E0.
- Outside RUN, slc_* outputs are 0.
- The sequencer does not interpret op or the sm/sa/sb semantics; it only routes them to the slice.
- Counter wrap is impossible: the counter is cleared on start and the FSM exits at WIDTH-1.

Decomposition:
- Shared package (alu_pkg): state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the op constants, including OP_ADD=2'b10.
- One natural sub-module: alu_serial_dp, containing the operand shift registers, result shift register and carry flop. The FSM and counter stay in alu_serial_seq.
- The slice itself is instantiated by the parent, not by this block.

Test Plan:
- The bench uses a behavioural slice model for op 2'b10: full adder on (a^sa, b^sb, c_in).
1. WIDTH=8, A=0x5A, B=0x3C, op=10, sa=sb=0, cin=0 -> done at E0+9, result_out=0x96, carry_out=0, zero=0. Cycle 1 shows slc_a=0, slc_b=0, slc_cin=0.
2. A=0xFF, B=0x01, cin=0 -> result_out=0x00, carry_out=1, zero=1, busy high for cycles 1..9.
3. Subtract: A=0x10, B=0x01, sb=1, cin=1 -> result_out=0x0F, carry_out=1. Cycle 1 shows slc_cin=1.
4. Reset mid-op: start A=0x5A, B=0x3C, drop rst_n at the 4th RUN edge -> next cycle busy=0, done never pulses, result_out=0. A fresh start then yields 0x96 at +9.
5. start held high continuously with B changed during RUN -> exactly one done per WIDTH+2 cycles, each result computed from the operands latched at its own start edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: FSM encoding,
// slice op codes and the bundle of slice controls latched per operation.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The sequencer only routes these to the slice; it never decodes them.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic       sm;
    logic       sa;
    logic       sb;
  } slc_ctl_t;

endpackage

// File: rtl/alu_serial_dp.sv
// Datapath for the serial ALU: operand shift registers feeding the slice
// LSB-first, the result shift register, carry feedback flop and flags.
module alu_serial_dp
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             last,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  slc_ctl_t         ctl_in,
  input  logic             cin_in,
  input  logic             slc_result,
  input  logic             slc_cout,
  output logic             bit_a,
  output logic             bit_b,
  output logic             cry,
  output slc_ctl_t         ctl,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  logic [WIDTH-1:0] a_sr, b_sr, res_nx;

  // Result enters at the MSB and walks down, so bit i settles at position i.
  assign res_nx = {slc_result, result[WIDTH-1:1]};
  assign bit_a  = a_sr[0];
  assign bit_b  = b_sr[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      ctl       <= '0;
      cry       <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (load) begin
      a_sr      <= a_in;
      b_sr      <= b_in;
      ctl       <= ctl_in;
      cry       <= cin_in;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      result <= res_nx;
      cry    <= slc_cout;
      if (last) begin
        carry_out <= slc_cout;
        zero      <= ~|res_nx;
      end
    end
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer: drives a 1-bit ALU slice for WIDTH cycles with
// carry feedback, then reports result/carry/zero with a done pulse.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op_in,
  input  logic             sm_in,
  input  logic             sa_in,
  input  logic             sb_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out,
  output logic             zero,
  output logic             slc_a,
  output logic             slc_b,
  output logic             slc_cin,
  output logic [1:0]       slc_op,
  output logic             slc_sm,
  output logic             slc_sa,
  output logic             slc_sb,
  input  logic             slc_result,
  input  logic             slc_cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt;
  logic             load, run, last;
  logic             bit_a, bit_b, cry;
  slc_ctl_t         ctl_in, ctl;

  assign ctl_in = '{op: op_in, sm: sm_in, sa: sa_in, sb: sb_in};
  assign load   = (state == ST_IDLE) && start;
  assign run    = (state == ST_RUN);
  assign last   = run && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (load)     cnt <= '0;
      else if (run) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (start) nstate = ST_RUN;
      ST_RUN:  if (last)  nstate = ST_DONE;
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // Slice pins are only live during RUN so the slice sees quiet inputs otherwise.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    slc_a   = 1'b0;
    slc_b   = 1'b0;
    slc_cin = 1'b0;
    slc_op  = 2'b00;
    slc_sm  = 1'b0;
    slc_sa  = 1'b0;
    slc_sb  = 1'b0;
    case (state)
      ST_RUN: begin
        busy    = 1'b1;
        slc_a   = bit_a;
        slc_b   = bit_b;
        slc_cin = cry;
        slc_op  = ctl.op;
        slc_sm  = ctl.sm;
        slc_sa  = ctl.sa;
        slc_sb  = ctl.sb;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  alu_serial_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .shift      (run),
    .last       (last),
    .a_in       (a_in),
    .b_in       (b_in),
    .ctl_in     (ctl_in),
    .cin_in     (cin_in),
    .slc_result (slc_result),
    .slc_cout   (slc_cout),
    .bit_a      (bit_a),
    .bit_b      (bit_b),
    .cry        (cry),
    .ctl        (ctl),
    .result     (result_out),
    .carry_out  (carry_out),
    .zero       (zero)
  );

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq with a behavioural 1-bit slice;
// expected results come from word-level arithmetic on the operands.
module tb_alu_serial_seq;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         z;
    int           due;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [1:0]   op_in = 2'b00;
  logic         sm_in = 1'b0, sa_in = 1'b0, sb_in = 1'b0, cin_in = 1'b0;
  logic         busy, done, carry_out, zero;
  logic [W-1:0] result_out;
  logic         slc_a, slc_b, slc_cin, slc_sm, slc_sa, slc_sb;
  logic [1:0]   slc_op;
  logic         slc_result, slc_cout;
  logic         s_x, s_y;
  logic [9:0]   obs;

  int   cyc = 0;
  int   vectors = 0, errors = 0;
  exp_t expq[$];
  exp_t mon_e;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .op_in(op_in), .sm_in(sm_in), .sa_in(sa_in), .sb_in(sb_in), .cin_in(cin_in),
    .busy(busy), .done(done), .result_out(result_out), .carry_out(carry_out),
    .zero(zero), .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
    .slc_op(slc_op), .slc_sm(slc_sm), .slc_sa(slc_sa), .slc_sb(slc_sb),
    .slc_result(slc_result), .slc_cout(slc_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slice: op 10 is a full adder on (a^sa, b^sb, c_in).
  always_comb begin
    s_x        = slc_a ^ slc_sa;
    s_y        = slc_b ^ slc_sb;
    slc_result = 1'b0;
    slc_cout   = 1'b0;
    case (slc_op)
      2'b00: slc_result = s_x & s_y;
      2'b01: slc_result = s_x | s_y;
      2'b10: begin
        slc_result = s_x ^ s_y ^ slc_cin;
        slc_cout   = (s_x & s_y) | (slc_cin & (s_x ^ s_y));
      end
      default: slc_result = s_x ^ s_y ^ slc_sm;
    endcase
  end

  assign obs = {busy, done, slc_a, slc_b, slc_cin, slc_op, slc_sm, slc_sa, slc_sb};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Word-level reference: {carry, result}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, b, input logic [1:0] op,
                                        input logic sm, sa, sb, cin);
    logic [W-1:0] ax, bx;
    ax = a ^ {W{sa}};
    bx = b ^ {W{sb}};
    case (op)
      2'b00:   return {1'b0, ax & bx};
      2'b01:   return {1'b0, ax | bx};
      2'b10:   return {1'b0, ax} + {1'b0, bx} + (W+1)'(cin);
      default: return {1'b0, ax ^ bx ^ {W{sm}}};
    endcase
  endfunction

  // Carry presented into each bit position during RUN.
  function automatic logic [W-1:0] ref_cins(input logic [W-1:0] a, b, input logic [1:0] op,
                                            input logic sa, sb, cin);
    logic [W-1:0] ax, bx;
    logic [W:0]   s;
    ax = a ^ {W{sa}};
    bx = b ^ {W{sb}};
    if (op != 2'b10) return W'(cin);
    s = {1'b0, ax} + {1'b0, bx} + (W+1)'(cin);
    return s[W-1:0] ^ ax ^ bx;
  endfunction

  function automatic exp_t mk_exp(input logic [W-1:0] a, b, input logic [1:0] op,
                                  input logic sm, sa, sb, cin, input int now);
    logic [W:0] r;
    exp_t e;
    r     = ref_op(a, b, op, sm, sa, sb, cin);
    e.res = r[W-1:0];
    e.cy  = r[W];
    e.z   = (r[W-1:0] == '0);
    e.due = now + W;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (expq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        mon_e = expq.pop_front();
        check("result", 32'(result_out), 32'(mon_e.res));
        check("carry", 32'(carry_out), 32'(mon_e.cy));
        check("zero", 32'(zero), 32'(mon_e.z));
        check("done_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, b, input logic [1:0] op,
                       input logic sm, sa, sb, cin);
    logic [W-1:0] cins;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; op_in = op;
    sm_in = sm; sa_in = sa; sb_in = sb; cin_in = cin;
    @(posedge clk); #1;
    start = 1'b0;
    expq.push_back(mk_exp(a, b, op, sm, sa, sb, cin, cyc));
    cins = ref_cins(a, b, op, sa, sb, cin);
    a_in = W'($urandom); b_in = W'($urandom); op_in = 2'($urandom);
    for (int i = 0; i < W; i++) begin
      check("run_bus", 32'(obs), 32'({1'b1, 1'b0, a[i], b[i], cins[i], op, sm, sa, sb}));
      @(posedge clk); #1;
    end
    check("done_bus", 32'(obs), 32'(10'b11_0000_0000));
    @(posedge clk); #1;
    check("idle_bus", 32'(obs), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus", 32'(obs), 32'd0);
    check("reset_flags", 32'({result_out, carry_out, zero}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(8'h10, 8'h01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);

    // Abort mid-operation: no done may follow, outputs clear.
    @(negedge clk);
    start = 1'b1; a_in = 8'h5A; b_in = 8'h3C; op_in = 2'b10;
    sm_in = 1'b0; sa_in = 1'b0; sb_in = 1'b0; cin_in = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_bus", 32'(obs), 32'd0);
    check("abort_flags", 32'({result_out, carry_out, zero}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_quiet", 32'(obs), 32'd0);
    do_op(8'h5A, 8'h3C, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      do_op(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // start held high: one accept every W+2 cycles, operands churning meanwhile.
    @(negedge clk);
    start = 1'b1; op_in = 2'b10; sm_in = 1'b0; sa_in = 1'b0; sb_in = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
    for (int c = 0; c < 4 * (W + 2); c++) begin
      @(posedge clk); #1;
      if (c % (W + 2) == 0)
        expq.push_back(mk_exp(a_in, b_in, op_in, sm_in, sa_in, sb_in, cin_in, cyc));
      @(negedge clk);
      a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
    end
    start = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("pending_results", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
